// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: requester, FIFO write-port and grant-status signals of the write arbiter
interface fifo_wr_arbiter_if #(
    parameter int DATASIZE = 8,
    parameter int NREQ     = 4
);
    localparam int IDW = $clog2(NREQ);
    logic [NREQ-1:0]          req_valid;
    logic [NREQ-1:0]          req_last;
    logic [NREQ*DATASIZE-1:0] req_data;
    logic [NREQ-1:0]          req_ready;
    logic                     wfull;
    logic                     winc;
    logic [DATASIZE-1:0]      wdata;
    logic                     grant_active;
    logic [IDW-1:0]           grant_id;
    logic                     burst_cut;
    modport master (
        output req_valid, req_last, req_data, wfull,
        input  req_ready, winc, wdata, grant_active, grant_id, burst_cut
    );
    modport slave (
        input  req_valid, req_last, req_data, wfull,
        output req_ready, winc, wdata, grant_active, grant_id, burst_cut
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-granted sharing of the async FIFO write port among NREQ requesters
module fifo_wr_arbiter #(
    parameter int DATASIZE = 8,
    parameter int NREQ     = 4,
    parameter int MAXBURST = 16
) (
    input logic wclk,
    input logic wrst,
    fifo_wr_arbiter_if.slave bus
);
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(MAXBURST + 1);
    typedef enum logic {IDLE, BURST} state_t;
    state_t         state;
    logic [IDW-1:0] last_grant, winner, cand;
    logic [CW-1:0]  beat_cnt;
    logic           cur_last, done;
    // scan from farthest to nearest so the nearest valid after last_grant wins
    always_comb begin
        winner = last_grant;
        cand   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = IDW'((int'(last_grant) + k) % NREQ);
            if (bus.req_valid[cand]) winner = cand;
        end
    end
    always_comb begin
        bus.wdata = '0;
        for (int i = 0; i < NREQ; i++)
            if (bus.grant_id == IDW'(i)) bus.wdata = bus.req_data[i*DATASIZE +: DATASIZE];
    end
    assign bus.winc      = bus.grant_active & bus.req_valid[bus.grant_id] & ~bus.wfull;
    assign bus.req_ready = (bus.grant_active & ~bus.wfull) ? (NREQ'(1) << bus.grant_id) : '0;
    assign cur_last      = bus.req_last[bus.grant_id];
    assign done          = bus.winc & (cur_last | (beat_cnt == CW'(MAXBURST - 1)));
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state            <= IDLE;
            bus.grant_active <= 1'b0;
            bus.grant_id     <= '0;
            bus.burst_cut    <= 1'b0;
            beat_cnt         <= '0;
            last_grant       <= IDW'(NREQ - 1);
        end else begin
            bus.burst_cut <= done & ~cur_last;
            if (state == IDLE && |bus.req_valid) begin
                state            <= BURST;
                bus.grant_active <= 1'b1;
                bus.grant_id     <= winner;
                beat_cnt         <= '0;
            end else if (state == BURST && bus.winc) begin
                beat_cnt <= beat_cnt + CW'(1);
                if (done) begin
                    state            <= IDLE;
                    bus.grant_active <= 1'b0;
                    last_grant       <= bus.grant_id;
                end
            end
        end
    end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-side arbiter that shares the single write port of the async FIFO (winc/wdata/wfull) among NREQ requesters in the write clock domain.
- Grants are per burst: a winner keeps the port until it transfers a beat with last=1 or until MAXBURST beats have been written.
- The block sits directly in front of the FIFO top. Its winc and wdata drive the FIFO, and its wfull input comes from the FIFO.

Parameters:
- DATASIZE, 8, data word width; matches the FIFO DATASIZE.
- NREQ, 4, number of requesters, 2..16.
- MAXBURST, 16, maximum beats per grant, >=1.

Ports:
- wclk  in  1  write-domain clock; all state is on its rising edge.
- wrst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester data valid.
- req_last  in  NREQ  per-requester end-of-packet marker, qualified by req_valid.
- req_data  in  NREQ*DATASIZE  packed data; requester i occupies bits [i*DATASIZE +: DATASIZE].
- req_ready  out  NREQ  per-requester accept; a beat transfers when valid & ready are both high.
- wfull  in  1  FIFO full flag.
- winc  out  1  FIFO write enable.
- wdata  out  DATASIZE  FIFO write data.
- grant_active  out  1  high while a burst is granted.
- grant_id  out  clog2(NREQ)  index of the current or most recent grantee.
- burst_cut  out  1  one-cycle registered pulse when a grant ends on MAXBURST without last.

Behaviour:
- State machine: IDLE, BURST.
- Reset values:
  - state=IDLE, grant_active=0, grant_id=0, beat_cnt=0, burst_cut=0.
  - last_grant=NREQ-1, so requester 0 has top priority after reset.
  - Combinational outputs under reset: winc=0, req_ready=0.
- IDLE:
  - If any req_valid is high, pick the first valid index scanning cyclically from last_grant+1.
  - Register grant_id=winner, grant_active=1, beat_cnt=0, and go to BURST.
  - Grant latency: the winner sees req_ready no earlier than the cycle after the valid is sampled in IDLE.
  - No valid: stay in IDLE.
- Combinational handshake:
  - req_ready[i] = grant_active & (i==grant_id) & ~wfull.
  - winc = grant_active & req_valid[grant_id] & ~wfull.
  - wdata = req_data slice of grant_id, always muxed, don't-care when winc=0.
- BURST, on each transfer (winc=1): beat_cnt increments.
  - Transfer with req_last=1: go to IDLE, grant_active=0, last_grant=grant_id.
  - Transfer with req_last=0 where beat_cnt==MAXBURST-1: go to IDLE, grant_active=0, last_grant=grant_id, burst_cut=1 for one cycle.
  - No transfer: hold the grant indefinitely. This covers both the grantee deasserting valid mid-packet and wfull being high. No timeout.
- Inter-burst gap: exactly one IDLE cycle between consecutive bursts, so maximum throughput is MAXBURST/(MAXBURST+1).
- grant_id holds its value in IDLE until the next arbitration.
- beat_cnt is clog2(MAXBURST+1) bits wide and cannot wrap; it clears on entering BURST.
- Boundary conditions:
  - wfull high in the same cycle as a last beat: no transfer, no state change; the beat completes in the first cycle with wfull=0.
  - MAXBURST=1: every grant is one beat; burst_cut pulses whenever that beat has last=0.
  - Non-grantee valid changes during BURST have no effect.
  - A requester dropping valid in IDLE before being granted is legal. Arbitration uses the valid vector sampled in the arbitration cycle only.
  - wrst asserted mid-burst: immediate return to reset values. A partially written packet stays in the FIFO; cleanup is the system's responsibility.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NREQ-1,0,...

Test Plan:
- Reset then single requester: req_valid=4'b0100, 3 beats with last on beat 3, wfull=0.
  - Expect grant_id=2 the cycle after valid.
  - Expect winc high for 3 consecutive cycles with wdata = requester-2 words in order.
  - Expect grant_active=0 after the last beat.
- All four requesters valid, 2-beat packets each:
  - Expect grant order 0,1,2,3,0 with one IDLE cycle between bursts.
  - Expect 8 beats written in 12 cycles after the first grant.
- MAXBURST=16, requester 1 sends 20 beats with last only on beat 20, requester 0 also valid:
  - Expect burst_cut pulse after beat 16.
  - Expect next grant to requester 2 if valid, else 3, else 0.
  - Expect requester 1 regranted later for the remaining 4 beats.
- wfull=1 asserted during beat 3 of 5 for 4 cycles:
  - Expect req_ready=0 and winc=0 for those 4 cycles with the grant held.
  - Expect beats 3..5 written afterwards with no duplicated or lost words.
- wrst pulsed mid-burst while grant_id=3:
  - Expect winc=0 and grant_active=0 immediately (asynchronous).
  - With all requesters valid after release, expect the first grant to go to requester 0.
- Grantee drops valid for 5 cycles mid-packet while others are valid:
  - Expect the grant held, no winc during the gap, and the packet completed before any other requester is granted.
